// File: rtl/pll_reset_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pll_reset_pkg : sequencer state encoding and counter-width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package pll_reset_pkg;

  localparam int STATE_W     = 2;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Bits needed to count 0 .. max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage : pll_reset_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a single asynchronous level, resets to 0
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pll_reset_sequencer : staged sys/cpu reset release gated by stable PLL lock
// Rev 1.0 -- optional lock-timeout PLL reset pulse enabled by PLL_LOCK_TIMEOUT_EN
// ----------------------------------------------------------------------------
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 16,
  parameter int PLL_RST_CYCLES      = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             cpu_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, STAGGER_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lk_s;
  logic          lock_loss;
  logic          hold;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lock_loss = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lk_s) state_nxt = STABLE;
      end
      STABLE: begin
        // A lock drop wins over a completing window and restarts it uncounted.
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = STAGGER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STAGGER: begin
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          lock_loss = 1'b1;
        end else if (cnt == STAGGER_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lk_s) begin
          state_nxt = WAIT_LOCK;
          lock_loss = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
    if (hold) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end
  end

  // Reset outputs are flops loaded from the next-state decode, so they
  // always mirror the state register and cannot glitch.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      sys_rst_n     <= 1'b0;
      cpu_rst_n     <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sys_rst_n <= (state_nxt == STAGGER) || (state_nxt == RUN);
      cpu_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      if (lock_loss && (lock_loss_cnt != '1)) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int TW = cnt_width(LOCK_TIMEOUT_CYCLES, 1);
  localparam int PW = cnt_width(PLL_RST_CYCLES, 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PRST_LAST    = PW'(PLL_RST_CYCLES - 1);

  logic [TW-1:0] timer;
  logic [PW-1:0] prst_cnt;
  logic          pll_rst_q;
  logic          trigger;

  // Timer is only ever non-zero in WAIT_LOCK/STABLE, so no state qualifier is needed.
  assign trigger = !pll_rst_q && (timer == TIMEOUT_LAST);
  assign hold    = pll_rst_q || trigger;
  assign pll_rst = pll_rst_q;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      timer     <= '0;
      prst_cnt  <= '0;
      pll_rst_q <= 1'b0;
    end else if (pll_rst_q) begin
      if (prst_cnt == PRST_LAST) begin
        pll_rst_q <= 1'b0;
        prst_cnt  <= '0;
        timer     <= '0;
      end else begin
        prst_cnt <= prst_cnt + 1'b1;
      end
    end else if (trigger) begin
      pll_rst_q <= 1'b1;
      prst_cnt  <= '0;
    end else if ((state_nxt == WAIT_LOCK) || (state_nxt == STABLE)) begin
      timer <= timer + 1'b1;
    end else begin
      timer <= '0;
    end
  end
`else
  assign hold = 1'b0;
  // Constant 0 for any legal configuration; timeout parameters only matter in the macro build.
  assign pll_rst = (PLL_RST_CYCLES < 1) || (LOCK_TIMEOUT_CYCLES < 1);
`endif

endmodule : pll_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pll_reset_sequencer : scoreboard bench for the staged PLL reset sequencer
// Rev 1.0 -- pulse expectations follow PLL_LOCK_TIMEOUT_EN
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int STAGGER_CYCLES      = 4;
    localparam int PLL_RST_CYCLES      = 3;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int CNT_W               = 8;

    // Cycles from driving pll_locked high to sys_rst_n release: sync + entry + window.
    localparam int REL     = 2 + 1 + LOCK_STABLE_CYCLES;
    localparam int CPU_REL = REL + STAGGER_CYCLES;

    // Flag order: {sys_rst_n, cpu_rst_n, ready, pll_rst}
    localparam logic [3:0] F_RST = 4'b0000;
    localparam logic [3:0] F_SYS = 4'b1000;
    localparam logic [3:0] F_RUN = 4'b1110;
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [3:0] F_PULSE = 4'b0001;
`else
    localparam logic [3:0] F_PULSE = 4'b0000;
`endif

    logic             clk;
    logic             rst_n;
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             cpu_rst_n;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_cnt;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
        .STAGGER_CYCLES      (STAGGER_CYCLES),
        .PLL_RST_CYCLES      (PLL_RST_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
        .CNT_W               (CNT_W)
    ) dut (
        .refclk        (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .cpu_rst_n     (cpu_rst_n),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       tag;
        logic [11:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input int at, input string tag, input logic [3:0] f, input logic [7:0] l);
        chk_t e;
        e.at  = at;
        e.tag = tag;
        e.exp = {f, l};
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    chk_t        cur;
    logic [11:0] obs;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            obs = {sys_rst_n, cpu_rst_n, ready, pll_rst, lock_loss_cnt};
            n_assert++;
            assert ((cur.at == cyc) && (obs === cur.exp)) else begin
                n_fail++;
                $error("FAIL %s cyc=%0d due=%0d observed=%b expected=%b", cur.tag, cyc, cur.at, obs, cur.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int          c;
    int          d;
    int          r;
    logic [7:0]  exp_llc;

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;

        // 1. cold start
        push(1, "reset_state", F_RST, 8'd0);
        push(3, "reset_hold", F_RST, 8'd0);
        tick(3);
        c = cyc;
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        push(c + REL - 1,     "cold_pre_release", F_RST, 8'd0);
        push(c + REL,         "cold_sys_release", F_SYS, 8'd0);
        push(c + CPU_REL - 1, "cold_stagger_end", F_SYS, 8'd0);
        push(c + CPU_REL,     "cold_run",         F_RUN, 8'd0);
        tick(CPU_REL + 2);
        n_assert++;
        if ((sys_rst_n !== 1'b1) || (cpu_rst_n !== 1'b1) || (ready !== 1'b1) || (lock_loss_cnt !== 8'd0)) begin
            n_fail++;
            $display("FAIL cold_run_direct sys=%b cpu=%b ready=%b llc=%0d", sys_rst_n, cpu_rst_n, ready, lock_loss_cnt);
        end

        // 2. one-cycle glitch in the 5th STABLE cycle restarts the window
        rst_n = 1'b0;
        push(cyc + 1, "glitch_reset", F_RST, 8'd0);
        tick(1);
        c = cyc;
        rst_n = 1'b1;
        push(c + REL,         "glitch_no_early_release", F_RST, 8'd0);
        push(c + REL + 7,     "glitch_pre_release",      F_RST, 8'd0);
        push(c + REL + 8,     "glitch_sys_release",      F_SYS, 8'd0);
        push(c + CPU_REL + 7, "glitch_stagger_end",      F_SYS, 8'd0);
        push(c + CPU_REL + 8, "glitch_run",              F_RUN, 8'd0);
        tick(7);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(CPU_REL + 2);

        // 3. lock loss in RUN, then relock
        d = cyc;
        pll_locked = 1'b0;
        push(d + 2, "loss_still_run", F_RUN, 8'd0);
        push(d + 3, "loss_reset",     F_RST, 8'd1);
        tick(5);
        c = cyc;
        pll_locked = 1'b1;
        push(c + REL - 1, "relock_pre_release", F_RST, 8'd1);
        push(c + REL,     "relock_sys_release", F_SYS, 8'd1);
        push(c + CPU_REL, "relock_run",         F_RUN, 8'd1);
        tick(CPU_REL + 1);
        n_assert++;
        if ((ready !== 1'b1) || (lock_loss_cnt !== 8'd1)) begin
            n_fail++;
            $display("FAIL relock_direct ready=%b llc=%0d", ready, lock_loss_cnt);
        end

        // 4. 260 further lock losses saturate the counter
        exp_llc = 8'd1;
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b1;
            tick(CPU_REL);
            d = cyc;
            pll_locked = 1'b0;
            push(d + 2, "sat_run", F_RUN, exp_llc);
            exp_llc = (exp_llc == 8'hFF) ? 8'hFF : exp_llc + 8'd1;
            push(d + 3, "sat_loss", F_RST, exp_llc);
            tick(5);
        end
        n_assert++;
        if (lock_loss_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_direct llc=%0d", lock_loss_cnt);
        end

        // 5. reset during STAGGER
        c = cyc;
        pll_locked = 1'b1;
        push(c + REL + 1, "mid_in_stagger", F_SYS, 8'd255);
        tick(REL + 1);
        rst_n = 1'b0;
        push(c + REL + 2, "mid_reset", F_RST, 8'd0);
        tick(1);
        c = cyc;
        rst_n = 1'b1;
        push(c + REL - 1, "mid_pre_release", F_RST, 8'd0);
        push(c + REL,     "mid_sys_release", F_SYS, 8'd0);
        push(c + CPU_REL, "mid_run",         F_RUN, 8'd0);
        tick(CPU_REL + 1);
        n_assert++;
        if ((ready !== 1'b1) || (lock_loss_cnt !== 8'd0)) begin
            n_fail++;
            $display("FAIL mid_direct ready=%b llc=%0d", ready, lock_loss_cnt);
        end

        // 6. lock never arrives: PLL reset pulses (macro build) or none
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        r = cyc + 1;
        push(r, "to_reset", F_RST, 8'd0);
        tick(1);
        rst_n = 1'b1;
        push(r + 31, "to_pre_pulse1",  F_RST,   8'd0);
        push(r + 32, "to_pulse1_rise", F_PULSE, 8'd0);
        push(r + 34, "to_pulse1_last", F_PULSE, 8'd0);
        push(r + 35, "to_pulse1_fall", F_RST,   8'd0);
        push(r + 66, "to_pre_pulse2",  F_RST,   8'd0);
        push(r + 67, "to_pulse2_rise", F_PULSE, 8'd0);
        push(r + 69, "to_pulse2_last", F_PULSE, 8'd0);
        push(r + 70, "to_pulse2_fall", F_RST,   8'd0);
        tick(72);
        n_assert++;
        if ((sys_rst_n !== 1'b0) || (cpu_rst_n !== 1'b0) || (ready !== 1'b0)) begin
            n_fail++;
            $display("FAIL to_direct sys=%b cpu=%b ready=%b", sys_rst_n, cpu_rst_n, ready);
        end

        for (int k = 0; k < 200 && sb.size() > 0; k++) tick(1);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            n_assert++;
            n_fail++;
            $display("FAIL %s never compared (due cyc %0d, now %0d)", cur.tag, cur.at, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_pll_reset_sequencer
`default_nettype wire
